adc_scan_sequencer: RTL

- Autonomous round-robin channel scanner that sits directly upstream of the MAX10 ADC IP's Avalon-ST command/response interface.
- Issues one conversion command per sample, checks each response and averages 2^AVG_LOG2 samples per channel.
- Stores one 12-bit averaged result per channel and exposes them over the 8-bit Wishbone FASM register port.
- Offloads software polling from the MCU core.

---
 rtl/adc_scan_sequencer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC channel scanner for the MAX10 ADC Avalon-ST command/response
// interface. Each channel is sampled 2^AVG_LOG2 times. The samples are averaged
// and the result is stored, then the scanner moves to the next channel. The
// stored results and the control/status are visible over an 8-bit Wishbone
// FASM register port.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   stb_i, we_i            Wishbone strobe / write enable (ack_o = stb_i)
//   adr_wr_i, dat_i        write address / data (write applied one cycle later)
//   adr_rd_i, dat_o        read address / combinational read data
//   command_*              ADC command (valid/ready, channel)
//   response_*             ADC response (valid, channel, 12-bit sample)
//   scan_done              sticky scan-complete flag, cleared by a CSR read
module adc_scan_sequencer #(
   parameter int unsigned NUM_CHANNELS       = 4,
   parameter int unsigned FIRST_CHANNEL      = 1,
   parameter int unsigned AVG_LOG2           = 2,
   parameter int unsigned TIMEOUT_CYCLES     = 1023,
   parameter logic [7:0]  REG_ADDR_CSR       = 8'hE0,
   parameter logic [7:0]  REG_ADDR_SEL       = 8'hE1,
   parameter logic [7:0]  REG_ADDR_DATA_HIGH = 8'hE2,
   parameter logic [7:0]  REG_ADDR_DATA_LOW  = 8'hE3,
   localparam int unsigned DATA_WIDTH        = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [DATA_WIDTH-1:0] adr_wr_i,
   input  logic [DATA_WIDTH-1:0] adr_rd_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic                  ack_o,
   output logic                  command_valid,
   output logic [4:0]            command_channel,
   input  logic                  command_ready,
   input  logic                  response_valid,
   input  logic [4:0]            response_channel,
   input  logic [11:0]           response_data,
   output logic                  scan_done
);

   localparam int unsigned AccW = 12 + AVG_LOG2;
   localparam int unsigned CntW = AVG_LOG2 + 1;
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] SampleCnt = CntW'(1 << AVG_LOG2);
   localparam logic [TmrW-1:0] TmrLast   = TmrW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]      IdxLast   = 3'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [AccW-1:0] acc_q, acc_d;
   logic [TmrW-1:0] tmr_q, tmr_d;
   logic            run_q, run_d;
   logic            cont_q, cont_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic [2:0]      sel_q;
   logic [7:0]      shadow_q;
   logic            we_q;
   logic [7:0]      addr_q;
   logic            store_en;

   logic            busy;
   logic            csr_wr, sel_wr, csr_rd, high_rd;
   logic [4:0]      cmd_chan;
   logic            resp_match;
   logic [CntW-1:0] cnt_inc;
   logic [11:0]     result_all [8];
   logic [11:0]     sel_result;
   logic            unused_dat;

   assign unused_dat = ^dat_i[7:4];

   assign busy       = (state_q != StIdle);
   assign csr_wr     = we_q && (addr_q == REG_ADDR_CSR);
   assign sel_wr     = we_q && (addr_q == REG_ADDR_SEL);
   assign csr_rd     = stb_i && !we_i && (adr_rd_i == REG_ADDR_CSR);
   assign high_rd    = stb_i && !we_i && (adr_rd_i == REG_ADDR_DATA_HIGH);
   assign cmd_chan   = 5'(FIRST_CHANNEL) + {2'b00, idx_q};
   assign resp_match = response_valid && (response_channel == cmd_chan);
   assign cnt_inc    = cnt_q + 1'b1;
   // Unused index slots read as zero, so out-of-range SEL values return 0.
   assign sel_result = result_all[sel_q];

   assign ack_o           = stb_i;
   assign command_valid   = (state_q == StIssue);
   assign command_channel = command_valid ? cmd_chan : 5'd0;
   assign scan_done       = done_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      tmr_d    = '0;
      run_d    = run_q;
      cont_d   = cont_q;
      err_d    = err_q;
      done_d   = done_q;
      store_en = 1'b0;

      if (csr_wr) begin
         cont_d = dat_i[1];
         // While busy, run can only be cleared; a run=1 write just updates continuous.
         if (!busy) begin
            run_d = dat_i[0];
         end else if (!dat_i[0]) begin
            run_d = 1'b0;
         end
         if (dat_i[3]) begin
            err_d = 1'b0;
         end
      end
      if (csr_rd) begin
         done_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (run_d) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (command_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (resp_match) begin
               acc_d   = acc_q + AccW'(response_data);
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == SampleCnt) ? StStore : StIssue;
            end else begin
               if (response_valid) begin
                  err_d = 1'b1;
               end
               if (tmr_q == TmrLast) begin
                  // Give up on this sample and reissue the same channel.
                  err_d   = 1'b1;
                  state_d = StIssue;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
         end
         StStore: begin
            store_en = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            if (!run_d) begin
               // Stopped by software: finish this channel, no completion flag.
               idx_d   = 3'd0;
               state_d = StIdle;
            end else if (idx_q == IdxLast) begin
               idx_d  = 3'd0;
               done_d = 1'b1;
               if (cont_d) begin
                  state_d = StIssue;
               end else begin
                  run_d   = 1'b0;
                  state_d = StIdle;
               end
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = StIssue;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         tmr_q    <= '0;
         run_q    <= 1'b0;
         cont_q   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         sel_q    <= '0;
         shadow_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         tmr_q  <= tmr_d;
         run_q  <= run_d;
         cont_q <= cont_d;
         err_q  <= err_d;
         done_q <= done_d;
         we_q   <= stb_i & we_i;
         addr_q <= adr_wr_i;
         if (sel_wr) begin
            sel_q <= dat_i[2:0];
         end
         // Low byte is frozen when the high byte is read, so the pair is tear-free.
         if (high_rd) begin
            shadow_q <= sel_result[7:0];
         end
      end
   end

   for (genvar g = 0; g < 8; g++) begin : gen_res
      if (g < NUM_CHANNELS) begin : gen_used
         logic [11:0] res_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               res_q <= '0;
            end else if (store_en && (idx_q == 3'(g))) begin
               res_q <= acc_q[11+AVG_LOG2:AVG_LOG2];
            end
         end
         assign result_all[g] = res_q;
      end else begin : gen_unused
         assign result_all[g] = '0;
      end
   end

   always_comb begin
      dat_o = '0;
      case (adr_rd_i)
         REG_ADDR_CSR:       dat_o = {4'b0000, err_q, done_q, cont_q, busy};
         REG_ADDR_SEL:       dat_o = {5'b00000, sel_q};
         REG_ADDR_DATA_HIGH: dat_o = {4'b0000, sel_result[11:8]};
         REG_ADDR_DATA_LOW:  dat_o = shadow_q;
         default:            dat_o = '0;
      endcase
   end

endmodule
